// File: rtl/adc_data_conv_multi_lane_pkg.sv
// adc_data_conv_multi_lane_pkg: shared format encodings and default statistics sizing
package adc_data_conv_multi_lane_pkg;
  localparam logic FMT_OFFSET_BIN = 1'b0;
  localparam logic FMT_TWOS = 1'b1;
  localparam int DEF_WIN_LEN = 1024;
  localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/adc_data_conv_multi_lane_lane_fmt.sv
// adc_lane_fmt: one lane of format conversion, negation, muting and overrange detection
module adc_lane_fmt
  import adc_data_conv_multi_lane_pkg::*;
#(
  parameter int W = 8,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [W-1:0]  din,
  input  logic          fmt,
  input  logic          inv,
  input  logic          mute,
  output logic [OW-1:0] dout,
  output logic          ovr
);
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};
  logic [W-1:0] d1, conv, res;
  logic v1, f1, i1, m1;
  always_ff @(posedge clk or posedge rst)
    if (rst) {d1, v1, f1, i1, m1} <= '0;
    else {d1, v1, f1, i1, m1} <= {din, din_valid, fmt, inv, mute};
  always_comb begin
    conv = (f1 == FMT_TWOS) ? d1 : {~d1[W-1], d1[W-2:0]};
    res = m1 ? '0 : !i1 ? conv : (conv == MIN) ? ~MIN : -conv;
  end
  // both formats map their extremes onto the two's-complement min/max codes
  assign ovr = v1 && (conv == MIN || conv == ~MIN);
  always_ff @(posedge clk or posedge rst)
    if (rst) dout <= '0;
    else if (v1) dout <= OW'($signed(res));
endmodule

// File: rtl/adc_data_conv_multi_lane.sv
// adc_data_conv_multi_lane: multi-lane ADC sample formatter with windowed overrange statistics
module adc_data_conv_multi_lane
  import adc_data_conv_multi_lane_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 8,
  parameter int LANE_NUM = 8,
  parameter int OUT_WIDTH = 8,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din_valid_i,
  input  logic [ADC_DATA_WIDTH*LANE_NUM-1:0] adc_all_bit_i,
  input  logic                           fmt_i,
  input  logic                           inv_i,
  input  logic                           mute_i,
  input  logic                           ovr_clr_i,
  output logic                           dout_valid_o,
  output logic [OUT_WIDTH*LANE_NUM-1:0]  adc_signed_all_bit_o,
  output logic                           ovr_flag_o,
  output logic [CNT_WIDTH-1:0]           ovr_cnt_o,
  output logic                           win_done_o
);
  localparam int PW = $clog2(LANE_NUM + 1);
  localparam int BW = $clog2(WIN_LEN);
  localparam int SW = CNT_WIDTH + PW;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  logic [LANE_NUM-1:0] ovr;
  logic [PW-1:0] pc, pc2;
  logic [BW-1:0] beat;
  logic [CNT_WIDTH-1:0] acc, sat;
  logic [SW-1:0] sum;
  logic v1, v2, last;
  for (genvar m = 0; m < LANE_NUM; m++) begin : g_lane
    adc_lane_fmt #(.W(ADC_DATA_WIDTH), .OW(OUT_WIDTH)) u_lane (
      .clk(clk), .rst(rst), .din_valid(din_valid_i),
      .din(adc_all_bit_i[m*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .fmt(fmt_i), .inv(inv_i), .mute(mute_i),
      .dout(adc_signed_all_bit_o[m*OUT_WIDTH +: OUT_WIDTH]),
      .ovr(ovr[m])
    );
  end
  always_comb begin
    pc = '0;
    for (int i = 0; i < LANE_NUM; i++) pc = pc + PW'(ovr[i]);
    sum = SW'(acc) + SW'(pc2);
    sat = (sum > SW'(CMAX)) ? CMAX : sum[CNT_WIDTH-1:0];
  end
  assign last = beat == BW'(WIN_LEN - 1);
  assign dout_valid_o = v2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v1, v2, pc2, beat, acc, ovr_cnt_o, win_done_o, ovr_flag_o} <= '0;
    end else begin
      v1 <= din_valid_i;
      v2 <= v1;
      pc2 <= pc;
      win_done_o <= v2 && last;
      if (v2 && pc2 != '0) ovr_flag_o <= 1'b1;
      else if (ovr_clr_i) ovr_flag_o <= 1'b0;
      if (v2) begin
        beat <= last ? '0 : beat + BW'(1);
        acc <= last ? '0 : sat;
        if (last) ovr_cnt_o <= sat;
      end
    end
endmodule

// File: tb/tb_adc_data_conv_multi_lane.sv
// tb_adc_data_conv_multi_lane: directed vectors against two parameterisations sharing one stimulus
module tb_adc_data_conv_multi_lane;
  logic clk = 0, rst = 1, din_valid = 0, fmt = 0, inv = 0, mute = 0, ovr_clr = 0;
  logic [63:0] adc = '0;
  logic dv_a, flag_a, done_a, dv_b, flag_b, done_b;
  logic [63:0] out_a;
  logic [95:0] out_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;
  int vec = 0, err = 0;
  always #5 clk = ~clk;
  adc_data_conv_multi_lane #(.ADC_DATA_WIDTH(8), .LANE_NUM(8), .OUT_WIDTH(8), .WIN_LEN(4), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .din_valid_i(din_valid), .adc_all_bit_i(adc), .fmt_i(fmt), .inv_i(inv),
    .mute_i(mute), .ovr_clr_i(ovr_clr), .dout_valid_o(dv_a), .adc_signed_all_bit_o(out_a),
    .ovr_flag_o(flag_a), .ovr_cnt_o(cnt_a), .win_done_o(done_a));
  adc_data_conv_multi_lane #(.ADC_DATA_WIDTH(8), .LANE_NUM(8), .OUT_WIDTH(12), .WIN_LEN(4), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .din_valid_i(din_valid), .adc_all_bit_i(adc), .fmt_i(fmt), .inv_i(inv),
    .mute_i(mute), .ovr_clr_i(ovr_clr), .dout_valid_o(dv_b), .adc_signed_all_bit_o(out_b),
    .ovr_flag_o(flag_b), .ovr_cnt_o(cnt_b), .win_done_o(done_b));
  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [63:0] d, input logic f, input logic i, input logic m);
    din_valid = 1; adc = d; fmt = f; inv = i; mute = m;
    step();
    din_valid = 0;
    step();
  endtask
  task automatic win_beat(input logic [63:0] d);
    beat(d, 0, 0, 0);
    step();
    step();
  endtask
  initial begin
    repeat (2) step();
    chk("rst_dout", out_a, 0); chk("rst_dout12", out_b, 0); chk("rst_valid", dv_a, 0);
    chk("rst_flag", flag_a, 0); chk("rst_cnt", cnt_a, 0); chk("rst_done", done_a, 0);
    rst = 0;
    step();
    beat(64'h80808080_7FFF8000, 0, 0, 0);
    chk("ob_dout", out_a, 64'h00000000_FF7F0080);
    chk("ob_dout12", out_b, 96'h000000000000_FFF07F000F80);
    chk("ob_valid", dv_a, 1);
    chk("ob_flag_early", flag_a, 0);
    step();
    chk("ob_flag", flag_a, 1);
    chk("ob_valid_drop", dv_a, 0);
    step();
    chk("ob_hold", out_a, 64'h00000000_FF7F0080);
    beat(64'h00000000_FF000180, 1, 1, 0);
    chk("tc_inv_dout", out_a, 64'h00000000_0100FF7F);
    chk("tc_inv_dout12", out_b, 96'h000000000000_001000FFF07F);
    step();
    beat(64'hFFFFFFFF_FFFFFFFF, 0, 0, 1);
    chk("mute_dout", out_a, 0);
    chk("mute_dout12", out_b, 0);
    step();
    chk("mute_done_lo", done_a, 0);
    beat(64'h80808080_80808080, 0, 0, 0);
    chk("zero_dout", out_a, 0);
    step();
    chk("w0_done", done_a, 1); chk("w0_cnt", cnt_a, 11); chk("w0_cnt4", cnt_b, 11);
    step();
    chk("w0_done_pulse", done_a, 0);
    for (int k = 0; k < 3; k++) win_beat(64'h80808080_8080FF00);
    chk("w1_done_lo", done_a, 0);
    chk("w1_cnt_hold", cnt_a, 11);
    beat(64'h80808080_8080FF00, 0, 0, 0);
    step();
    chk("w1_done", done_a, 1); chk("w1_cnt", cnt_a, 8); chk("w1_cnt4", cnt_b, 8);
    for (int k = 0; k < 4; k++) win_beat(64'h80808080_80808080);
    chk("w2_cnt", cnt_a, 0); chk("w2_cnt4", cnt_b, 0);
    for (int k = 0; k < 3; k++) win_beat(64'hFFFFFFFF_FFFFFFFF);
    beat(64'hFFFFFFFF_FFFFFFFF, 0, 0, 0);
    step();
    chk("sat_done", done_b, 1); chk("sat_cnt", cnt_a, 32); chk("sat_cnt4", cnt_b, 15);
    step();
    ovr_clr = 1; step(); ovr_clr = 0;
    chk("clr_alone", flag_a, 0);
    beat(64'h80808080_8080FF00, 0, 0, 0);
    ovr_clr = 1; step(); ovr_clr = 0;
    chk("clr_vs_set", flag_a, 1);
    ovr_clr = 1; step(); ovr_clr = 0;
    chk("clr_again", flag_a, 0);
    win_beat(64'h80808080_8080FF00);
    rst = 1;
    #2;
    chk("mrst_dout", out_a, 0); chk("mrst_dout12", out_b, 0); chk("mrst_flag", flag_a, 0);
    chk("mrst_cnt", cnt_a, 0); chk("mrst_valid", dv_a, 0); chk("mrst_done", done_a, 0);
    rst = 0;
    step();
    for (int k = 0; k < 3; k++) win_beat(64'h80808080_808080FF);
    chk("mrst_w_done_lo", done_a, 0);
    chk("mrst_w_cnt_lo", cnt_a, 0);
    beat(64'h80808080_808080FF, 0, 0, 0);
    step();
    chk("mrst_w_done", done_a, 1); chk("mrst_w_cnt", cnt_a, 4); chk("mrst_w_cnt4", cnt_b, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
